dsm_interp_upsampler: RTL and testbench
=======================================

// Module: dsm_interp_upsampler
// PURPOSE
//  Linear-interpolating upsampler directly upstream of dsm_top. Accepts 20-bit signed
//  samples at the low rate through a valid/ready handshake and buffers them in a 2-entry
//  FIFO. Emits one 20-bit signed sample on every fast clock to drive the modulator vin
//  input, ramping linearly between successive inputs over R fast cycles.
// PARAMETERS
//  W        20      sample width (signed, two's complement)
//  R        50      upsample ratio (fast cycles per input sample), 4..255
//  SHIFT    16      fractional bits of reciprocal constant
//  INV_R    1311    round(2^SHIFT / R); produced by the package function for the chosen R
// PORTS
//  clock      in   1   fast clock (modulator rate)
//  reset      in   1   synchronous, active-high
//  din        in   W   signed input sample
//  din_valid  in   1   din holds a sample
//  din_ready  out  1   FIFO not full; a transfer occurs when din_valid && din_ready
//  vout       out  W   signed interpolated sample, to dsm_top vin
//  vout_valid out  1   vout is a live interpolated or held value (state != IDLE)
//  underrun   out  1   sticky; set when a segment ends with the FIFO empty
// BEHAVIOUR
//  Reset (1 cycle sufficient, any time, including mid-segment):
//   vout=0, vout_valid=0, underrun=0, din_ready=1, FIFO empty, phase=0,
//   x_prev=0, acc=0, step=0, state=IDLE. A sample presented during reset is dropped.
//  FIFO: 2 entries, registered. Push and pop in the same cycle are allowed when full.
//  States:
//   IDLE: wait until FIFO is non-empty. Pop to x_next and register
//    step=((x_next-x_prev)*INV_R)>>>SHIFT (arithmetic shift, floor). Go to RUN,
//    phase=0. Handshake-to-first-vout_valid latency is 2 cycles.
//   RUN: vout=acc. Each cycle: acc+=step, phase+=1.
//    At phase==R-2, pop the next sample if the FIFO is non-empty, and compute the next diff.
//    At phase==R-1 (wrap), snap acc=x_next and x_prev=x_next (drift is discarded),
//    phase=0, and load step from the pre-computed value.
//    If no sample was popped at R-2, go to HOLD at the wrap.
//   HOLD: vout=x_prev (zero-order hold), vout_valid=1, underrun<=1.
//    On the first cycle in which the FIFO is non-empty, pop, compute step, and re-enter RUN
//    with phase=0.
//  Arithmetic:
//   diff is W+1 bits. Product is W+1+SHIFT+1 bits.
//   step is clamped to W+1 bits signed.
//   acc is W+2 bits. vout saturates acc to [-2^(W-1), 2^(W-1)-1].
//  Segment cadence is exactly R cycles while input keeps pace. Input arriving faster than
//  1/R fills the FIFO, and din_ready then drops; no sample is ever lost or overwritten.
//  underrun clears only on reset.
// STRUCTURE
//  Shared package dsm_pkg holds:
//   W_SAMPLE=20
//   function inv_r(R, SHIFT)
//   the state enum {IDLE, RUN, HOLD}
//  Sub-module: dsm_sample_fifo (2-deep valid/ready FIFO, parameter W).
//  The interpolation datapath and FSM stay in this module.
// TESTING (R=50, INV_R=1311, SHIFT=16)
//  1. Reset, then din=50000 once, then idle
//     -> vout 0,1000,2000,...,49000, then 50000 held;
//        vout_valid rises 2 cycles after the transfer; underrun=1 at the wrap.
//  2. Ramp down: din=-50000 from x_prev=0 -> step=-1001; vout 0,-1001,...;
//     exactly -50000 at the wrap (snap).
//  3. Extremes: 524287 then -524288 back-to-back, paced every 50 cycles
//     -> vout never leaves the 20-bit range; endpoints are exact at each wrap.
//  4. Burst of 4 samples on consecutive cycles
//     -> din_ready low after 2 are buffered; all 4 segments appear in order, 50 cycles
//        each, with no gaps and no underrun.
//  5. Continuous input every 50 cycles for 1000 samples
//     -> underrun stays 0; each vout at a wrap equals the input sample.
//  6. Reset asserted at phase 25 of a segment
//     -> next cycle vout=0, vout_valid=0, FIFO empty, underrun=0; normal restart afterwards.

Source files
------------

// File: rtl/dsm_pkg.sv
// Shared definitions for the modulator front end: sample width, interpolator
// state encoding and the reciprocal-constant helper.
package dsm_pkg;

  localparam int unsigned W_SAMPLE = 20;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } interp_state_e;

  // round(2^shift / r), so a divide by R becomes a multiply and shift
  function automatic int unsigned inv_r(input int unsigned r, input int unsigned shift);
    return ((32'd1 << shift) + (r / 2)) / r;
  endfunction

endpackage

// File: rtl/dsm_sample_fifo.sv
// Two-entry registered FIFO with show-ahead read data; a push is accepted
// while full if a pop happens in the same cycle.
module dsm_sample_fifo #(
  parameter int unsigned W = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push_ok;
  logic         pop_ok;

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd2);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dsm_interp_upsampler.sv
// Linear-interpolating upsampler feeding dsm_top vin: ramps from the previous
// sample to the next over R fast cycles, holding the last value on underrun.
module dsm_interp_upsampler
  import dsm_pkg::*;
#(
  parameter int unsigned W     = W_SAMPLE,
  parameter int unsigned R     = 50,
  parameter int unsigned SHIFT = 16,
  parameter int unsigned INV_R = inv_r(R, SHIFT)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic signed [W-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic signed [W-1:0] vout,
  output logic                vout_valid,
  output logic                underrun
);

  localparam int unsigned PW = W + SHIFT + 2;
  localparam logic signed [PW-1:0] INV_X    = PW'(INV_R);
  localparam logic signed [PW-1:0] STEP_MAX = {{(PW-W){1'b0}}, {W{1'b1}}};
  localparam logic signed [PW-1:0] STEP_MIN = {{(PW-W){1'b1}}, {W{1'b0}}};
  localparam logic signed [W+1:0]  ACC_MAX  = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0]  ACC_MIN  = {3'b111, {(W-1){1'b0}}};
  localparam logic [7:0]           PH_POP   = 8'(R - 2);
  localparam logic [7:0]           PH_LAST  = 8'(R - 1);

  interp_state_e      state, state_n;
  logic [7:0]         phase, phase_n;
  logic signed [W+1:0] acc, acc_n;
  logic signed [W:0]  step, step_n, step_pend, step_pend_n;
  logic [W-1:0]       x_prev, x_prev_n, x_next, x_next_n, x_pend, x_pend_n;
  logic               have_pend, have_pend_n;
  logic               underrun_n;
  logic               fifo_pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [W-1:0]       fifo_data;

  function automatic logic signed [W:0] calc_step(input logic [W-1:0] tgt,
                                                  input logic [W-1:0] base);
    logic signed [W:0]    diff;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] sh;
    diff = $signed({tgt[W-1], tgt}) - $signed({base[W-1], base});
    prod = PW'(diff) * INV_X;
    sh   = prod >>> SHIFT;
    if (sh > STEP_MAX) return {1'b0, {W{1'b1}}};
    if (sh < STEP_MIN) return {1'b1, {W{1'b0}}};
    return sh[W:0];
  endfunction

  function automatic logic signed [W+1:0] widen(input logic [W-1:0] x);
    return {{2{x[W-1]}}, x};
  endfunction

  dsm_sample_fifo #(.W(W)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (din_valid && din_ready),
    .push_data (din),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign din_ready  = !fifo_full;
  assign vout_valid = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      acc       <= '0;
      step      <= '0;
      step_pend <= '0;
      x_prev    <= '0;
      x_next    <= '0;
      x_pend    <= '0;
      have_pend <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      acc       <= acc_n;
      step      <= step_n;
      step_pend <= step_pend_n;
      x_prev    <= x_prev_n;
      x_next    <= x_next_n;
      x_pend    <= x_pend_n;
      have_pend <= have_pend_n;
      underrun  <= underrun_n;
    end
  end

  // The sample popped at R-2 lands in x_pend so x_next stays the snap target
  // for the wrap one cycle later.
  always_comb begin
    state_n     = state;
    phase_n     = phase;
    acc_n       = acc;
    step_n      = step;
    step_pend_n = step_pend;
    x_prev_n    = x_prev;
    x_next_n    = x_next;
    x_pend_n    = x_pend;
    have_pend_n = have_pend;
    underrun_n  = underrun;
    fifo_pop    = 1'b0;
    unique case (state)
      IDLE, HOLD: begin
        if (state == HOLD) underrun_n = 1'b1;
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          x_next_n    = fifo_data;
          step_n      = calc_step(fifo_data, x_prev);
          acc_n       = widen(x_prev);
          phase_n     = '0;
          have_pend_n = 1'b0;
          state_n     = RUN;
        end
      end
      RUN: begin
        acc_n   = acc + {step[W], step};
        phase_n = phase + 8'd1;
        if (phase == PH_POP && !fifo_empty) begin
          fifo_pop    = 1'b1;
          x_pend_n    = fifo_data;
          step_pend_n = calc_step(fifo_data, x_next);
          have_pend_n = 1'b1;
        end
        if (phase == PH_LAST) begin
          acc_n    = widen(x_next);
          x_prev_n = x_next;
          phase_n  = '0;
          if (have_pend) begin
            x_next_n    = x_pend;
            step_n      = step_pend;
            have_pend_n = 1'b0;
          end else begin
            state_n    = HOLD;
            underrun_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    vout = '0;
    unique case (state)
      RUN: begin
        if (acc > ACC_MAX)      vout = {1'b0, {(W-1){1'b1}}};
        else if (acc < ACC_MIN) vout = {1'b1, {(W-1){1'b0}}};
        else                    vout = acc[W-1:0];
      end
      HOLD:    vout = x_prev;
      default: vout = '0;
    endcase
  end

endmodule

// File: tb/tb_dsm_interp_upsampler.sv
// Scoreboard bench for dsm_interp_upsampler at R=50, SHIFT=16, INV_R=1311:
// each accepted sample queues its expected 50-cycle ramp.
module tb_dsm_interp_upsampler;

  localparam int R   = 50;
  localparam int INV = 1311;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               din_valid = 1'b0;
  logic signed [19:0] din = '0;
  logic               din_ready;
  logic signed [19:0] vout;
  logic               vout_valid;
  logic               underrun;

  int  vec_cnt = 0;
  int  err_cnt = 0;
  int  exp_q[$];
  int  model_prev = 0;
  int  mon_exp;
  bit  mon_en = 1'b0;

  always #5 clock = ~clock;

  dsm_interp_upsampler #(.W(20), .R(50), .SHIFT(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .vout       (vout),
    .vout_valid (vout_valid),
    .underrun   (underrun)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat20(input longint v);
    if (v > 524287)  return 524287;
    if (v < -524288) return -524288;
    return int'(v);
  endfunction

  task automatic model_push(input int x);
    longint diff, st;
    diff = longint'(x) - longint'(model_prev);
    st   = (diff * INV) >>> 16;
    if (st > 1048575)  st = 1048575;
    if (st < -1048576) st = -1048576;
    for (int p = 0; p < R; p++) exp_q.push_back(sat20(longint'(model_prev) + p * st));
    model_prev = x;
  endtask

  always @(negedge clock) begin
    if (mon_en && !reset && vout_valid) begin
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("vout", vout, mon_exp);
        check("underrun_run", underrun, 0);
      end else begin
        check("vout_hold", vout, model_prev);
      end
    end
  end

  // Entered and left at posedge+1; one reset edge is applied.
  task automatic do_reset();
    mon_en    = 1'b0;
    reset     = 1'b1;
    din_valid = 1'b0;
    @(posedge clock); #1;
    check("rst_vout", vout, 0);
    check("rst_vout_valid", vout_valid, 0);
    check("rst_underrun", underrun, 0);
    check("rst_din_ready", din_ready, 1);
    reset = 1'b0;
    exp_q.delete();
    model_prev = 0;
    mon_en = 1'b1;
  endtask

  task automatic send(input int x);
    logic rdy;
    int   n;
    n = 0;
    din       = 20'(x);
    din_valid = 1'b1;
    forever begin
      rdy = din_ready;
      @(posedge clock); #1;
      n++;
      if (rdy) begin
        model_push(x);
        break;
      end
      if (n > 500) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clock); #1;

    // single ramp up, then zero-order hold with underrun
    do_reset();
    send(50000);
    check("valid_lat1", vout_valid, 0);
    @(posedge clock); #1;
    check("valid_lat2", vout_valid, 1);
    check("vout_first", vout, 0);
    wait_drain(200);
    check("underrun_set", underrun, 1);
    check("hold_value", vout, 50000);
    repeat (3) @(posedge clock);
    #1;

    // ramp down, floor rounding of the step
    do_reset();
    send(-50000);
    wait_drain(200);
    check("snap_neg", vout, -50000);

    // full-scale extremes back to back
    do_reset();
    send(524287);
    send(-524288);
    send(524287);
    send(-524288);
    wait_drain(400);

    // burst of four on consecutive cycles
    do_reset();
    send(1000);
    send(-2000);
    send(30000);
    check("din_ready_full", din_ready, 0);
    send(7);
    wait_drain(400);

    // long continuous random stream
    do_reset();
    for (int i = 0; i < 1000; i++) send(int'($urandom_range(0, 1048575)) - 524288);
    wait_drain(400);

    // reset at phase 25 of a segment
    do_reset();
    send(100000);
    send(200000);
    repeat (25) @(posedge clock);
    #1;
    do_reset();
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("fifo_empty_after_reset", vout_valid, 0);
    send(-3000);
    wait_drain(200);
    check("restart_hold", vout, -3000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
